trace_capture: RTL

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_if.sv | 27 ++
 rtl/trace_capture.sv | 136 +++++++++++++
 2 files changed

// File: rtl/trace_capture_if.sv
// Sample bus and readout handshake for the trace capture buffer.
// master drives samples and rd_ready; slave is the capture unit.
interface trace_capture_if #(
    parameter int WIDTH = 16
);
    logic             sample_valid;
    logic [WIDTH-1:0] sample_data;
    logic [WIDTH-1:0] trig_mask;
    logic [WIDTH-1:0] trig_value;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output sample_valid, sample_data,
        output trig_mask, trig_value,
        output rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  sample_valid, sample_data,
        input  trig_mask, trig_value,
        input  rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/trace_capture.sv
// Triggered trace buffer: keeps a window of pre-trigger samples,
// fills the rest after a masked compare hit, then drains oldest-first.
module trace_capture #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    trace_capture_if.slave         bus,
    output logic [1:0]             state_out,
    output logic                   triggered,
    output logic [$clog2(DEPTH):0] count_out
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    localparam logic [AW-1:0] P_ONE  = 1;
    localparam logic [AW:0]   C_ONE  = 1;
    localparam logic [AW:0]   PRE_N  = PRE_TRIG;
    localparam logic [AW:0]   POST_N = DEPTH - PRE_TRIG;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   post_q, post_d;
    logic          trig_q, trig_d;
    logic          we;
    logic          hit;
    logic          rd_valid;

    assign hit = bus.sample_valid &&
                 ((bus.sample_data & bus.trig_mask) ==
                  (bus.trig_value & bus.trig_mask));

    assign rd_valid = (state_q == S_READOUT) && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        trig_d   = trig_q;
        we       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    post_d   = '0;
                end
            end
            S_ARMED: begin
                if (bus.sample_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + P_ONE;
                    if (hit) begin
                        count_d = count_q + C_ONE;
                        post_d  = C_ONE;
                        trig_d  = 1'b1;
                        state_d = (POST_N == C_ONE) ? S_READOUT
                                                    : S_CAPTURE;
                    end else if (count_q == PRE_N) begin
                        // window full: drop the oldest pre-trigger entry
                        rd_ptr_d = rd_ptr_q + P_ONE;
                    end else begin
                        count_d = count_q + C_ONE;
                    end
                end
            end
            S_CAPTURE: begin
                if (bus.sample_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + P_ONE;
                    count_d  = count_q + C_ONE;
                    post_d   = post_q + C_ONE;
                    if (post_q == POST_N - C_ONE) begin
                        state_d = S_READOUT;
                    end
                end
            end
            S_READOUT: begin
                if (rd_valid && bus.rd_ready) begin
                    rd_ptr_d = rd_ptr_q + P_ONE;
                    count_d  = count_q - C_ONE;
                    if (count_q == C_ONE) begin
                        state_d = S_IDLE;
                        trig_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            trig_q   <= trig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem_q[wr_ptr_q] <= bus.sample_data;
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign state_out    = state_q;
    assign triggered    = trig_q;
    assign count_out    = count_q;
endmodule
